// File: rtl/crypto_cpu_core_if.sv
// Memory-side bus of crypto_cpu_core: instruction fetch port and data port,
// both using a level req held until ack.
interface crypto_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/crypto_cpu_core.sv
// Multi-cycle crypto CPU: 16-bit instructions fetched over req/ack, data
// memory over req/ack, halt/error reporting and a retired-instruction counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for run
// S_FETCH | imem_req high, waiting for imem_ack
// S_EXEC  | decode and execute latched instruction
// S_MEM   | dmem_req high, waiting for dmem_ack (LD/ST)
// S_HALT  | stopped by HALT or illegal opcode; left only through reset
module crypto_cpu_core #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    parameter int PC_W   = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    crypto_cpu_core_if.master   bus,
    output logic                halted,
    output logic                error,
    output logic [CNT_W-1:0]    instret
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);

    state_t              state, state_n;
    logic [PC_W-1:0]     pc, pc_n;
    logic [15:0]         inst, inst_n;
    logic [DATA_W-1:0]   regs [16];
    logic                imem_req, imem_req_n;
    logic                dmem_req, dmem_req_n;
    logic                dmem_we, dmem_we_n;
    logic [ADDR_W-1:0]   dmem_addr, dmem_addr_n;
    logic [DATA_W-1:0]   dmem_wdata, dmem_wdata_n;
    logic                halted_n, error_n;
    logic [CNT_W-1:0]    instret_n;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;

    logic [3:0]          op, rd, rs1, rs2;
    logic [7:0]          imm8;
    logic [DATA_W-1:0]   a, b, d, sh, alu;

    assign op   = inst[15:12];
    assign rd   = inst[11:8];
    assign rs1  = inst[7:4];
    assign rs2  = inst[3:0];
    assign imm8 = inst[7:0];
    assign a    = regs[rs1];
    assign b    = regs[rs2];
    assign d    = regs[rd];
    assign sh   = b % DW;

    always_comb begin
        alu = '0;
        case (op)
            4'h0:       alu = a + b;
            4'h1:       alu = a - b;
            4'h2:       alu = a & b;
            4'h3:       alu = a | b;
            4'h4, 4'h8: alu = a ^ b;
            4'h5:       alu = a << sh;
            4'h6:       alu = a >> sh;
            4'hA:       alu = DATA_W'(imm8);
            // a >> DW is zero, so a rotate by 0 needs no special case
            4'hC:       alu = (a << sh) | (a >> (DW - sh));
            default:    alu = '0;
        endcase
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_n       = inst;
        imem_req_n   = imem_req;
        dmem_req_n   = dmem_req;
        dmem_we_n    = dmem_we;
        dmem_addr_n  = dmem_addr;
        dmem_wdata_n = dmem_wdata;
        halted_n     = halted;
        error_n      = error;
        instret_n    = instret;
        wr_en        = 1'b0;
        wr_data      = alu;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_n    = S_FETCH;
                    imem_req_n = 1'b1;
                end
            end
            S_FETCH: begin
                if (imem_req && bus.imem_ack) begin
                    inst_n     = bus.imem_rdata;
                    imem_req_n = 1'b0;
                    state_n    = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    4'h7, 4'h9: begin
                        dmem_req_n   = 1'b1;
                        dmem_we_n    = (op == 4'h9);
                        dmem_addr_n  = a[ADDR_W-1:0];
                        dmem_wdata_n = b;
                        state_n      = S_MEM;
                    end
                    4'hF: begin
                        halted_n = 1'b1;
                        state_n  = S_HALT;
                    end
                    4'hE: begin
                        halted_n = 1'b1;
                        error_n  = 1'b1;
                        state_n  = S_HALT;
                    end
                    default: begin
                        if (op == 4'hB && d == '0) pc_n = PC_W'(imm8);
                        else                       pc_n = pc + 1'b1;
                        wr_en      = (op != 4'hB) && (op != 4'hD);
                        instret_n  = instret + 1'b1;
                        imem_req_n = 1'b1;
                        state_n    = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_req && bus.dmem_ack) begin
                    wr_en      = !dmem_we;
                    wr_data    = bus.dmem_rdata;
                    dmem_req_n = 1'b0;
                    dmem_we_n  = 1'b0;
                    pc_n       = pc + 1'b1;
                    instret_n  = instret + 1'b1;
                    imem_req_n = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            inst       <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            error      <= 1'b0;
            instret    <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            imem_req   <= imem_req_n;
            dmem_req   <= dmem_req_n;
            dmem_we    <= dmem_we_n;
            dmem_addr  <= dmem_addr_n;
            dmem_wdata <= dmem_wdata_n;
            halted     <= halted_n;
            error      <= error_n;
            instret    <= instret_n;
            // unimplemented registers are never written and so read as 0
            if (wr_en && int'(rd) < NREGS) regs[rd] <= wr_data;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.dmem_addr  = dmem_addr;
    assign bus.dmem_wdata = dmem_wdata;
endmodule

// File: tb/tb_crypto_cpu_core.sv
// Scoreboard bench for crypto_cpu_core: memory models on both ports, expected
// fetches and stores queued by the stimulus and compared by monitors.
module tb_crypto_cpu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        run16 = 1'b0;
    logic        halted, error, halted16, error16;
    logic [15:0] instret, instret16;

    crypto_cpu_core_if #(.DATA_W(8),  .PC_W(8), .ADDR_W(8)) bus();
    crypto_cpu_core_if #(.DATA_W(16), .PC_W(8), .ADDR_W(8)) bus16();

    crypto_cpu_core dut (
        .clk(clk), .reset(reset), .run(run), .bus(bus),
        .halted(halted), .error(error), .instret(instret)
    );

    crypto_cpu_core #(.DATA_W(16), .NREGS(8)) dut16 (
        .clk(clk), .reset(reset), .run(run16), .bus(bus16),
        .halted(halted16), .error(error16), .instret(instret16)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [15:0] rom   [256];
    logic [15:0] rom16 [256];
    logic [7:0]  ram   [256];
    logic [15:0] ram16 [256];
    int  dly = 0;
    bit  hold = 1'b0;
    bit  force_ack = 1'b0;
    int  dcnt = 0;
    int  req_len = 0;
    int  wr_count = 0;
    int  wr_10_count = 0;
    int  unstable = 0;
    int  ptr = 0;
    logic [7:0]  acc_addr, acc_wdata;
    logic        acc_we;
    int          q_len    [$];
    logic [7:0]  q_fetch  [$];
    logic [15:0] q_st     [$];
    logic [23:0] q_st16   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // main data/instruction memory: ack decided mid-cycle for the next edge
    always @(negedge clk) begin
        bus.imem_ack   = bus.imem_req;
        bus.imem_rdata = rom[bus.imem_addr];
        if (bus.dmem_req) begin
            if (req_len == 0) begin
                acc_addr = bus.dmem_addr; acc_we = bus.dmem_we; acc_wdata = bus.dmem_wdata;
            end else if (bus.dmem_addr !== acc_addr || bus.dmem_we !== acc_we ||
                         bus.dmem_wdata !== acc_wdata) begin
                unstable++;
            end
            req_len++;
            if (!hold && dcnt >= dly) begin bus.dmem_ack = 1'b1; dcnt = 0; end
            else begin bus.dmem_ack = 1'b0; dcnt++; end
        end else begin
            bus.dmem_ack = 1'b0; dcnt = 0; req_len = 0;
        end
        if (force_ack) bus.dmem_ack = 1'b1;
        bus.dmem_rdata = ram[bus.dmem_addr];
        if (bus.dmem_req && bus.dmem_ack) begin
            q_len.push_back(req_len);
            req_len = 0;
            if (bus.dmem_we) begin
                ram[bus.dmem_addr] = bus.dmem_wdata;
                wr_count++;
                if (bus.dmem_addr == 8'h10) wr_10_count++;
            end
        end
    end

    always @(negedge clk) begin
        bus16.imem_ack   = bus16.imem_req;
        bus16.imem_rdata = rom16[bus16.imem_addr];
        bus16.dmem_ack   = bus16.dmem_req;
        bus16.dmem_rdata = ram16[bus16.dmem_addr];
    end

    // monitors
    always @(negedge clk) begin
        #1;
        if (bus.imem_req && bus.imem_ack) begin
            if (q_fetch.size() == 0) begin
                checks++; failures++;
                $display("FAIL fetch_unexpected: got addr 0x%0h expected no fetch", bus.imem_addr);
            end else check("fetch_addr", bus.imem_addr, q_fetch.pop_front());
        end
        if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
            if (q_st.size() == 0) begin
                checks++; failures++;
                $display("FAIL store_unexpected: got 0x%0h<=0x%0h expected no store", bus.dmem_addr, bus.dmem_wdata);
            end else check("store", {bus.dmem_addr, bus.dmem_wdata}, q_st.pop_front());
        end
        if (bus16.dmem_req && bus16.dmem_ack && bus16.dmem_we) begin
            if (q_st16.size() == 0) begin
                checks++; failures++;
                $display("FAIL store16_unexpected: got 0x%0h<=0x%0h expected no store", bus16.dmem_addr, bus16.dmem_wdata);
            end else check("store16", {bus16.dmem_addr, bus16.dmem_wdata}, q_st16.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; run = 1'b0; run16 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        ptr = 0;
    endtask

    task automatic emit(input logic [15:0] w);
        rom[ptr] = w;
        ptr++;
    endtask

    task automatic fetch_linear(input int n);
        for (int i = 0; i < n; i++) q_fetch.push_back(8'(i));
    endtask

    task automatic run_prog(input int budget, output int edges);
        edges = 0;
        @(negedge clk);
        run = 1'b1;
        while (!halted && edges < budget) begin
            @(negedge clk);
            edges++;
        end
        run = 1'b0;
        if (!halted) begin
            checks++; failures++;
            $display("FAIL halt_timeout: got halted=0 expected 1 within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    task automatic end_of_prog(input string tag, input logic [15:0] n_ret, input logic [7:0] pc,
                               input logic err);
        check({tag, "_halted"},  halted, 1'b1);
        check({tag, "_error"},   error, err);
        check({tag, "_instret"}, instret, n_ret);
        check({tag, "_pc"},      bus.imem_addr, pc);
        check({tag, "_fetch_q"}, q_fetch.size(), 0);
        check({tag, "_store_q"}, q_st.size(), 0);
    endtask

    initial begin
        int edges;
        int n;
        int wc;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int n;
        int wc;

        // reset state
        clear_rom();
        do_reset();
        @(negedge clk);
        check("rst_halted", halted, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_instret", instret, 0);
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_dmem_req", bus.dmem_req, 1'b0);
        check("rst_pc", bus.imem_addr, 0);

        // LDI/LDI/XENC then store the result; zero-wait latency
        emit(16'hA15A); emit(16'hA2FF); emit(16'h8312); emit(16'h9013); emit(16'hF000);
        fetch_linear(5);
        q_st.push_back({8'h5A, 8'hA5});
        dly = 0;
        run_prog(100, edges);
        check("t1_edges", edges, 12);
        check("t1_imem_req", bus.imem_req, 1'b0);
        end_of_prog("t1", 16'd4, 8'h04, 1'b0);

        // store then load with 3 wait states per data access
        do_reset();
        clear_rom();
        emit(16'hA110); emit(16'hA23C); emit(16'h9012); emit(16'h7410);
        emit(16'hA620); emit(16'h9064); emit(16'hF000);
        fetch_linear(7);
        q_st.push_back({8'h10, 8'h3C});
        q_st.push_back({8'h20, 8'h3C});
        dly = 3; q_len.delete(); unstable = 0; wr_count = 0; wr_10_count = 0;
        run_prog(200, edges);
        check("t2_edges", edges, 27);
        check("t2_accesses", q_len.size(), 3);
        while (q_len.size() > 0) check("t2_req_len", q_len.pop_front(), 4);
        check("t2_unstable", unstable, 0);
        check("t2_writes_0x10", wr_10_count, 1);
        check("t2_writes", wr_count, 2);
        end_of_prog("t2", 16'd6, 8'h06, 1'b0);
        dly = 0;

        // BEQZ taken then not taken
        do_reset();
        clear_rom();
        rom[8'h00] = 16'hA500; rom[8'h01] = 16'hB520;
        rom[8'h20] = 16'hA501; rom[8'h21] = 16'hB530; rom[8'h22] = 16'hF000;
        rom[8'h30] = 16'hE000;
        q_fetch.push_back(8'h00); q_fetch.push_back(8'h01); q_fetch.push_back(8'h20);
        q_fetch.push_back(8'h21); q_fetch.push_back(8'h22);
        run_prog(100, edges);
        end_of_prog("t3", 16'd4, 8'h22, 1'b0);

        // illegal opcode at 0x07, then run is ignored
        do_reset();
        clear_rom();
        for (int i = 0; i < 7; i++) emit(16'hD000);
        emit(16'hE000);
        fetch_linear(8);
        run_prog(100, edges);
        end_of_prog("t4", 16'd7, 8'h07, 1'b1);
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (4) @(negedge clk);
        run = 1'b0;
        check("t4_still_halted", halted, 1'b1);
        check("t4_still_error", error, 1'b1);
        check("t4_pc_frozen", bus.imem_addr, 8'h07);
        check("t4_no_fetch", bus.imem_req, 1'b0);

        // pc wraps 0xFF -> 0x00, r0 writable
        do_reset();
        clear_rom();
        rom[8'h00] = 16'hB0FF; rom[8'hFF] = 16'hA001; rom[8'h01] = 16'hF000;
        q_fetch.push_back(8'h00); q_fetch.push_back(8'hFF);
        q_fetch.push_back(8'h00); q_fetch.push_back(8'h01);
        run_prog(100, edges);
        end_of_prog("t7", 16'd3, 8'h01, 1'b0);

        // ALU operations, shift amounts taken mod 8
        do_reset();
        clear_rom();
        emit(16'hA1F0); emit(16'hA23C); emit(16'h0312); emit(16'h2412); emit(16'h4512);
        emit(16'h1621); emit(16'hA809); emit(16'h5728); emit(16'h6918); emit(16'h3A12);
        emit(16'h9003); emit(16'h9004); emit(16'h9005); emit(16'h9006); emit(16'h9007);
        emit(16'h9009); emit(16'h900A); emit(16'hF000);
        fetch_linear(18);
        q_st.push_back({8'h00, 8'h2C}); q_st.push_back({8'h00, 8'h30});
        q_st.push_back({8'h00, 8'hCC}); q_st.push_back({8'h00, 8'h4C});
        q_st.push_back({8'h00, 8'h78}); q_st.push_back({8'h00, 8'h78});
        q_st.push_back({8'h00, 8'hFC});
        run_prog(200, edges);
        end_of_prog("t8", 16'd17, 8'h11, 1'b0);

        // reset while a store waits for dmem_ack
        do_reset();
        clear_rom();
        emit(16'hA144); emit(16'h9011); emit(16'hF000);
        q_fetch.push_back(8'h00); q_fetch.push_back(8'h01);
        hold = 1'b1;
        @(negedge clk);
        run = 1'b1;
        n = 0;
        while (!bus.dmem_req && n < 20) begin @(negedge clk); n++; end
        check("t6_mem_wait", bus.dmem_req, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0; run = 1'b0;
        @(negedge clk);
        check("t6_dmem_req", bus.dmem_req, 1'b0);
        check("t6_dmem_we", bus.dmem_we, 1'b0);
        check("t6_dmem_addr", bus.dmem_addr, 0);
        check("t6_imem_req", bus.imem_req, 1'b0);
        check("t6_pc", bus.imem_addr, 0);
        check("t6_instret", instret, 0);
        check("t6_halted", halted, 1'b0);
        wc = wr_count;
        @(negedge clk);
        reset = 1'b1; hold = 1'b0; force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        check("t6_late_ack_req", bus.dmem_req, 1'b0);
        check("t6_idle", bus.imem_req, 1'b0);
        check("t6_no_write", wr_count, wc);
        // r1 must have been cleared by the reset
        clear_rom();
        emit(16'h9021); emit(16'hF000);
        fetch_linear(2);
        q_st.push_back({8'h00, 8'h00});
        run_prog(100, edges);
        end_of_prog("t6", 16'd1, 8'h01, 1'b0);

        // 16-bit datapath with 8 registers
        do_reset();
        for (int i = 0; i < 256; i++) rom16[i] = 16'hF000;
        rom16[0]  = 16'hA180; rom16[1]  = 16'hA208; rom16[2]  = 16'h5112; rom16[3]  = 16'hA301;
        rom16[4]  = 16'h3113; rom16[5]  = 16'hC413; rom16[6]  = 16'hA977; rom16[7]  = 16'h9054;
        rom16[8]  = 16'h9039; rom16[9]  = 16'h6613; rom16[10] = 16'h9026; rom16[11] = 16'hA711;
        rom16[12] = 16'hC717; rom16[13] = 16'h9077; rom16[14] = 16'h1053; rom16[15] = 16'h9030;
        q_st16.push_back({8'h00, 16'h0003});
        q_st16.push_back({8'h01, 16'h0000});
        q_st16.push_back({8'h08, 16'h4000});
        q_st16.push_back({8'h03, 16'h0003});
        q_st16.push_back({8'h01, 16'hFFFF});
        @(negedge clk);
        run16 = 1'b1;
        n = 0;
        while (!halted16 && n < 300) begin @(negedge clk); n++; end
        run16 = 1'b0;
        @(negedge clk);
        check("t5_halted", halted16, 1'b1);
        check("t5_error", error16, 1'b0);
        check("t5_instret", instret16, 16);
        check("t5_store_q", q_st16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
